// File: rtl/goal_referee.sv
// -----------------------------------------------------------------------------
// goal_referee
//   Samples the ball position once per frame, detects goals in the left and
//   right goal mouths, keeps both players' scores, drives the ball block's
//   centerBall input for the kickoff pause and declares game over at WIN_SCORE.
//
// Ports
//   frame_clk   in   frame-rate clock, shared with the ball block
//   Reset       in   asynchronous, active-high
//   BallX/Y/S   in   ball centre x, centre y, radius (10-bit unsigned pixels)
//   enable      in   1 = goal detection active in PLAY
//   restart     in   level; clears scores and starts a kickoff pause
//   centerBall  out  registered recentre request to the ball block
//   score1      out  player 1 goals (scored in the right goal)
//   score2      out  player 2 goals (scored in the left goal)
//   goal_flash  out  high during the post-goal pause
//   scorer      out  00 none, 01 player 1, 10 player 2 (winner when game_over)
//   game_over   out  high once a player reaches WIN_SCORE
// -----------------------------------------------------------------------------
module goal_referee #(
    parameter int GOAL_LEFT_X  = 26,
    parameter int GOAL_RIGHT_X = 613,
    parameter int GOAL_Y_MIN   = 190,
    parameter int GOAL_Y_MAX   = 290,
    parameter int HOLD_FRAMES  = 120,
    parameter int WIN_SCORE    = 7
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    input  logic       enable,
    input  logic       restart,
    output logic       centerBall,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       goal_flash,
    output logic [1:0] scorer,
    output logic       game_over
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);

    localparam logic [10:0]   LEFT_X   = 11'(GOAL_LEFT_X);
    localparam logic [10:0]   RIGHT_X  = 11'(GOAL_RIGHT_X);
    localparam logic [9:0]    Y_MIN    = 10'(GOAL_Y_MIN);
    localparam logic [9:0]    Y_MAX    = 10'(GOAL_Y_MAX);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HOLD      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    // Every registered output plus the pause counter, updated as one bundle.
    typedef struct packed {
        logic          center;
        logic          flash;
        logic [3:0]    s1;
        logic [3:0]    s2;
        logic [1:0]    scorer;
        logic          over;
        logic [CW-1:0] cnt;
    } regs_t;

    state_t state, state_nxt;
    regs_t  r, r_nxt;

    // ------------------------------------------------------------------
    // Goal geometry. Sums are 11 bits wide so x + radius never wraps.
    // An x of 768 or more is a ball that ran past 0 and wrapped, so it
    // counts as being beyond the left goal line.
    // ------------------------------------------------------------------
    logic [10:0] x11, s11;
    logic        left_x, right_x, in_mouth;
    logic        goal_left, goal_right, goal_evt;
    logic [3:0]  new_score;
    logic        win;

    always_comb begin
        x11        = {1'b0, BallX};
        s11        = {1'b0, BallS};
        left_x     = (x11 <= (LEFT_X + s11)) || (BallX >= 10'd768);
        right_x    = ((x11 + s11) >= RIGHT_X);
        in_mouth   = (BallY >= Y_MIN) && (BallY <= Y_MAX);
        goal_left  = left_x && in_mouth;
        goal_right = right_x && in_mouth;
        goal_evt   = enable && (goal_left || goal_right);
        // Left wins a tie so a single event only ever bumps one score.
        new_score  = goal_left ? (r.s2 + 4'd1) : (r.s1 + 4'd1);
        win        = (new_score == WIN);
    end

    // ------------------------------------------------------------------
    // State register and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= PLAY;
            r     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = HOLD;
        end else begin
            case (state)
                PLAY: begin
                    if (goal_evt)
                        state_nxt = win ? GAME_OVER : HOLD;
                end
                HOLD: begin
                    if (r.cnt == '0)
                        state_nxt = PLAY;
                end
                GAME_OVER: state_nxt = GAME_OVER;
                default:   state_nxt = PLAY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        r_nxt = r;
        if (restart) begin
            // Held restart keeps reloading the counter, so the kickoff
            // pause is measured from the last frame restart was seen.
            r_nxt.s1     = '0;
            r_nxt.s2     = '0;
            r_nxt.scorer = 2'b00;
            r_nxt.over   = 1'b0;
            r_nxt.flash  = 1'b0;
            r_nxt.center = 1'b1;
            r_nxt.cnt    = CNT_LOAD;
        end else begin
            case (state)
                PLAY: begin
                    if (goal_evt) begin
                        if (goal_left) begin
                            r_nxt.s2     = new_score;
                            r_nxt.scorer = 2'b10;
                        end else begin
                            r_nxt.s1     = new_score;
                            r_nxt.scorer = 2'b01;
                        end
                        r_nxt.center = 1'b1;
                        if (win) begin
                            r_nxt.over  = 1'b1;
                            r_nxt.flash = 1'b0;
                        end else begin
                            r_nxt.flash = 1'b1;
                            r_nxt.cnt   = CNT_LOAD;
                        end
                    end
                end
                HOLD: begin
                    // The goal frame plus HOLD_FRAMES-1 counted frames gives
                    // exactly HOLD_FRAMES frames of centerBall high.
                    if (r.cnt == '0) begin
                        r_nxt.center = 1'b0;
                        r_nxt.flash  = 1'b0;
                    end else begin
                        r_nxt.cnt = r.cnt - 1'b1;
                    end
                end
                GAME_OVER: begin
                    r_nxt.center = 1'b1;
                    r_nxt.over   = 1'b1;
                end
                default: r_nxt = r;
            endcase
        end
    end

    assign centerBall = r.center;
    assign goal_flash = r.flash;
    assign score1     = r.s1;
    assign score2     = r.s2;
    assign scorer     = r.scorer;
    assign game_over  = r.over;

endmodule

// File: tb/tb_goal_referee.sv
// -----------------------------------------------------------------------------
// tb_goal_referee
//   Table of single-frame vectors from reset, hand-written multi-frame
//   sequences (pause length, held goal, game over, restart, async reset), and
//   a randomized run compared against a frame-indexed reference model.
// -----------------------------------------------------------------------------
module tb_goal_referee;

    localparam int HOLD = 120;
    localparam int WINS = 7;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic [9:0] BallX = 10'd320, BallY = 10'd240, BallS = 10'd4;
    logic       enable = 1'b1, restart = 1'b0;
    logic       centerBall, goal_flash, game_over;
    logic [3:0] score1, score2;
    logic [1:0] scorer;

    int total = 0;
    int passed = 0;

    goal_referee dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .enable    (enable),
        .restart   (restart),
        .centerBall(centerBall),
        .score1    (score1),
        .score2    (score2),
        .goal_flash(goal_flash),
        .scorer    (scorer),
        .game_over (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input int s1, input int s2, input int sc,
                             input int cen, input int fl, input int ov);
        chk({tag, ".score1"},     int'(score1),     s1);
        chk({tag, ".score2"},     int'(score2),     s2);
        chk({tag, ".scorer"},     int'(scorer),     sc);
        chk({tag, ".centerBall"}, int'(centerBall), cen);
        chk({tag, ".goal_flash"}, int'(goal_flash), fl);
        chk({tag, ".game_over"},  int'(game_over),  ov);
    endtask

    // Called at a negedge; drives one frame's inputs and returns at the next negedge.
    task automatic step(input int bx, input int by, input int bs, input bit en, input bit rs);
        BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs);
        enable = en; restart = rs;
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        BallX = 10'd320; BallY = 10'd240; BallS = 10'd4; enable = 1'b1; restart = 1'b0;
        @(negedge frame_clk);
        Reset = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    // Counts further frames with centerBall high, ball parked mid-field (bounded).
    task automatic count_high(input bit en, output int n);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            step(320, 240, 4, en, 1'b0);
            if (centerBall) n++;
            else break;
        end
    endtask

    // ---------------- reference model ----------------
    // Time is a frame index; a pause is "frames before hold_end", and the
    // frame at hold_end is the return-to-play frame where goals are ignored.
    longint mf, m_hold_end;
    int     m_s1, m_s2, m_scorer;
    bit     m_over, m_flash;

    task automatic model_reset();
        mf = 0; m_hold_end = -1;
        m_s1 = 0; m_s2 = 0; m_scorer = 0; m_over = 0; m_flash = 0;
    endtask

    task automatic model_step(input int bx, input int by, input int bs, input bit en, input bit rs);
        bit lft, rgt, mouth;
        mf++;
        mouth = (by >= 190) && (by <= 290);
        lft   = mouth && ((bx <= 26 + bs) || (bx >= 768));
        rgt   = mouth && (bx + bs >= 613);
        if (rs) begin
            m_s1 = 0; m_s2 = 0; m_scorer = 0; m_over = 0; m_flash = 0;
            m_hold_end = mf + HOLD;
        end else if (!m_over && mf > m_hold_end && en && (lft || rgt)) begin
            if (lft) begin m_s2++; m_scorer = 2; end
            else     begin m_s1++; m_scorer = 1; end
            if (m_s1 == WINS || m_s2 == WINS) begin
                m_over = 1; m_flash = 0;
            end else begin
                m_flash = 1; m_hold_end = mf + HOLD;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int bx, by, bs;
        bit en, rs;
        int s1, s2, sc;
        bit cen, fl, ov;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    initial begin
        int n;
        int bx, by, bs;
        bit en, rs;

        vt[0]  = '{20,   240, 4, 1, 0, 0, 1, 2, 1, 1, 0};
        vt[1]  = '{612,  240, 4, 1, 0, 1, 0, 1, 1, 1, 0};
        vt[2]  = '{612,  100, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{612,  190, 4, 1, 0, 1, 0, 1, 1, 1, 0};
        vt[4]  = '{612,  290, 4, 1, 0, 1, 0, 1, 1, 1, 0};
        vt[5]  = '{612,  189, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{612,  291, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{22,   240, 4, 1, 0, 0, 1, 2, 1, 1, 0};
        vt[8]  = '{31,   240, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{1020, 240, 4, 1, 0, 0, 1, 2, 1, 1, 0};
        vt[10] = '{20,   240, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{609,  240, 4, 1, 0, 1, 0, 1, 1, 1, 0};
        vt[12] = '{608,  240, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{768,  100, 4, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{20,   240, 4, 1, 1, 0, 0, 0, 1, 0, 0};

        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            step(vt[i].bx, vt[i].by, vt[i].bs, vt[i].en, vt[i].rs);
            check_all($sformatf("vec%0d", i), vt[i].s1, vt[i].s2, vt[i].sc,
                      vt[i].cen, vt[i].fl, vt[i].ov);
        end

        // ---- goal held 5 frames, second goal during pause, pause length ----
        do_reset();
        for (int k = 0; k < 5; k++) step(20, 240, 4, 1'b1, 1'b0);
        chk("held_goal.score2", int'(score2), 1);
        step(612, 240, 4, 1'b1, 1'b0);
        check_all("hold_second_goal", 0, 1, 2, 1, 1, 0);
        count_high(1'b1, n);
        chk("hold_frames", 6 + n, HOLD);
        check_all("after_hold", 0, 1, 2, 0, 0, 0);

        // ---- play up to game over ----
        do_reset();
        for (int g = 0; g < WINS; g++) begin
            step(612, 240, 4, 1'b1, 1'b0);
            chk($sformatf("win_run.goal%0d", g), int'(score1), g + 1);
            if (g < WINS - 1)
                for (int k = 0; k < HOLD; k++) step(320, 240, 4, 1'b1, 1'b0);
        end
        check_all("game_over", 7, 0, 1, 1, 0, 1);
        step(612, 240, 4, 1'b1, 1'b0);
        step(20, 240, 4, 1'b1, 1'b0);
        check_all("game_over_frozen", 7, 0, 1, 1, 0, 1);

        // restart held for 3 frames; pause counts from the last one
        step(320, 240, 4, 1'b1, 1'b1);
        check_all("restart", 0, 0, 0, 1, 0, 0);
        step(320, 240, 4, 1'b1, 1'b1);
        step(320, 240, 4, 1'b1, 1'b1);
        count_high(1'b1, n);
        chk("restart_hold_frames", 1 + n, HOLD);
        chk("restart_back_to_play.game_over", int'(game_over), 0);
        step(612, 240, 4, 1'b1, 1'b0);
        chk("restart_then_goal.score1", int'(score1), 1);

        // ---- async reset in the middle of a pause ----
        do_reset();
        step(20, 240, 4, 1'b1, 1'b0);
        for (int k = 0; k < 69; k++) step(320, 240, 4, 1'b1, 1'b0);
        chk("pre_reset.centerBall", int'(centerBall), 1);
        #2 Reset = 1'b1;
        #1 check_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // ---- randomized run against the model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            bx = int'($urandom_range(0, 1023));
            by = int'($urandom_range(150, 330));
            bs = int'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 699) == 0);
            step(bx, by, bs, en, rs);
            model_step(bx, by, bs, en, rs);
            check_all($sformatf("rand%0d", i), m_s1, m_s2, m_scorer,
                      int'(m_over || (mf < m_hold_end)),
                      int'(m_flash && (mf < m_hold_end)), int'(m_over));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
